// File: rtl/tone_pwm_if.sv
// Control/status bundle between the note sequencer and the tone PWM.
interface tone_pwm_if #(
  parameter int unsigned W = 32
);
  logic         en;
  logic         load;
  logic [W-1:0] period_in;
  logic [W-1:0] duty_in;
  logic         pwm_out;
  logic         period_done;
  logic         pending;
  logic         active;

  modport master (
    output en, load, period_in, duty_in,
    input  pwm_out, period_done, pending, active
  );

  modport slave (
    input  en, load, period_in, duty_in,
    output pwm_out, period_done, pending, active
  );
endinterface

// File: rtl/tone_pwm.sv
// Glitch-free square-wave tone generator with double-buffered period/duty;
// all updates and enable changes take effect only at a period boundary.
module tone_pwm #(
  parameter int unsigned W = 32
) (
  input  logic     clk,
  input  logic     rst,
  tone_pwm_if.slave bus
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [W-1:0] TWO = W'(2);

  logic [0:0]   state, state_nxt;
  logic [W-1:0] cnt, cnt_nxt;
  logic [W-1:0] act_p, act_p_nxt, act_d, act_d_nxt;
  logic [W-1:0] shd_p, shd_p_nxt, shd_d, shd_d_nxt;
  logic [W-1:0] eff_p, eff_d;
  logic         pend_q, pend_nxt;
  logic         pwm_q, pwm_nxt;
  logic         done_q, done_nxt;
  logic         active_q, active_nxt;
  logic         boundary, apply;

  // Next-state, buffer update and output lookahead.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    act_p_nxt = act_p;
    act_d_nxt = act_d;
    shd_p_nxt = shd_p;
    shd_d_nxt = shd_d;
    pend_nxt  = pend_q;
    apply     = 1'b0;
    eff_p     = bus.load ? bus.period_in : (pend_q ? shd_p : act_p);
    eff_d     = bus.load ? bus.duty_in   : (pend_q ? shd_d : act_d);
    boundary  = (state == S_RUN) && (cnt == act_p - ONE);

    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (bus.en && (eff_p >= TWO)) begin
          state_nxt = S_RUN;
          apply     = 1'b1;
        end
      end
      S_RUN: begin
        if (boundary) begin
          apply   = 1'b1;
          cnt_nxt = '0;
          if (!bus.en || (eff_p < TWO)) state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (apply) begin
      act_p_nxt = eff_p;
      act_d_nxt = eff_d;
      pend_nxt  = 1'b0;
    end else if (bus.load) begin
      shd_p_nxt = bus.period_in;
      shd_d_nxt = bus.duty_in;
      pend_nxt  = 1'b1;
    end

    // Outputs are flopped from next-state values so they align with cnt.
    active_nxt = (state_nxt == S_RUN);
    pwm_nxt    = active_nxt && (cnt_nxt < act_d_nxt);
    done_nxt   = active_nxt && (cnt_nxt == act_p_nxt - ONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      act_p    <= '0;
      act_d    <= '0;
      shd_p    <= '0;
      shd_d    <= '0;
      pend_q   <= 1'b0;
      pwm_q    <= 1'b0;
      done_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      act_p    <= act_p_nxt;
      act_d    <= act_d_nxt;
      shd_p    <= shd_p_nxt;
      shd_d    <= shd_d_nxt;
      pend_q   <= pend_nxt;
      pwm_q    <= pwm_nxt;
      done_q   <= done_nxt;
      active_q <= active_nxt;
    end
  end

  assign bus.pwm_out     = pwm_q;
  assign bus.period_done = done_q;
  assign bus.pending     = pend_q;
  assign bus.active      = active_q;

endmodule

// File: tb/tb_tone_pwm.sv
// Scoreboard bench for tone_pwm: a note-level reference model predicts each
// cycle's outputs, a monitor compares them after every rising edge.
module tb_tone_pwm;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tone_pwm_if #(.W(W)) bus ();
  tone_pwm #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic pwm;
    logic done;
    logic pend;
    logic act;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  // Reference model: which note is sounding, where in its period we are,
  // and which note (if any) is queued for the next period.
  bit              m_run;
  bit              m_pend;
  longint unsigned m_pos, m_p, m_d, m_sp, m_sd;

  task automatic model_reset();
    m_run = 0; m_pend = 0; m_pos = 0; m_p = 0; m_d = 0; m_sp = 0; m_sd = 0;
  endtask

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got pwm/done/pend/act=%b want %b at %0t", name, got, want, $time);
    end
  endtask

  // One cycle of stimulus; the expected outputs after the next edge are queued.
  task automatic step(input bit en, input bit ld, input longint unsigned p, input longint unsigned d);
    longint unsigned np, nd;
    @(negedge clk);
    bus.en = en; bus.load = ld; bus.period_in = W'(p); bus.duty_in = W'(d);
    np = ld ? p : (m_pend ? m_sp : m_p);
    nd = ld ? d : (m_pend ? m_sd : m_d);
    if (!m_run) begin
      if (en && np >= 2) begin
        m_run = 1; m_pos = 0; m_p = np; m_d = nd; m_pend = 0;
      end else if (ld) begin
        m_sp = p; m_sd = d; m_pend = 1;
      end
    end else if (m_pos + 1 == m_p) begin
      m_p = np; m_d = nd; m_pend = 0; m_pos = 0;
      m_run = en && (np >= 2);
    end else begin
      m_pos++;
      if (ld) begin m_sp = p; m_sd = d; m_pend = 1; end
    end
    q.push_back('{pwm: m_run && (m_pos < m_d), done: m_run && (m_pos + 1 == m_p),
                  pend: m_pend, act: m_run});
  endtask

  // Idle-step until the model says the cycle being sampled has cnt == n.
  task automatic to_pos(input bit en, input longint unsigned n);
    for (int i = 0; i < 64 && !(m_run && m_pos == n); i++) step(en, 0, 0, 0);
    checks++;
    if (!(m_run && m_pos == n)) begin
      errors++;
      $display("FAIL to_pos: got run=%0d pos=%0d want pos=%0d", m_run, m_pos, n);
    end
  endtask

  task automatic run(input int n, input bit en);
    for (int i = 0; i < n; i++) step(en, 0, 0, 0);
  endtask

  // Monitor: every edge presents one output sample.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && q.size() > 0) begin
        e = q.pop_front();
        check("cycle", {bus.pwm_out, bus.period_done, bus.pending, bus.active}, e);
      end
    end
  end

  // Reset between edges: outputs must clear without waiting for a clock.
  task automatic async_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check("async_reset", {bus.pwm_out, bus.period_done, bus.pending, bus.active}, 4'b0000);
    model_reset();
    bus.en = 0; bus.load = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.en = 0; bus.load = 0; bus.period_in = '0; bus.duty_in = '0;
    model_reset();
    #2 check("reset_state", {bus.pwm_out, bus.period_done, bus.pending, bus.active}, 4'b0000);
    @(negedge clk);
    rst = 1'b0;

    // Basic tone 4/2.
    step(1, 1, 4, 2);
    run(11, 1);
    // Deferred update to 6/3 loaded at cnt=1.
    to_pos(1, 1);
    step(1, 1, 6, 3);
    run(14, 1);
    // Graceful stop from 8/4 with en dropped at cnt=2.
    to_pos(1, 5);
    step(1, 1, 8, 4);
    to_pos(1, 2);
    run(10, 0);
    // Clamps: duty 0, duty >= period, period 1.
    step(1, 1, 5, 0);
    run(12, 1);
    to_pos(1, 4);
    step(1, 1, 5, 9);
    run(12, 1);
    to_pos(0, 4);
    run(3, 0);
    step(1, 1, 1, 1);
    run(5, 1);
    // Load exactly on the boundary of a 4/2 run.
    step(1, 1, 4, 2);
    to_pos(1, 3);
    step(1, 1, 3, 1);
    run(8, 1);
    // Async reset mid-run at cnt=2, then silence until a new load.
    step(1, 1, 8, 4);
    to_pos(1, 1);
    step(1, 0, 0, 0);
    async_reset();
    run(6, 1);
    step(1, 1, 3, 2);
    run(6, 1);

    // Randomized phase.
    for (int i = 0; i < 600; i++) begin
      bit en, ld;
      en = ($urandom_range(0, 9) != 0);
      ld = ($urandom_range(0, 7) == 0);
      step(en, ld, longint'($urandom_range(0, 9)), longint'($urandom_range(0, 11)));
    end
    run(4, 1);

    @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d queued want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tone_pwm.md
# tone_pwm

Glitch-free square-wave tone generator that drives the buzzer pin from the period/duty pair computed by the note sequencer. New period/duty values are double-buffered and take effect only at a PWM period boundary. Enable changes also take effect only at a boundary, so note changes, pauses and resumes never produce truncated or runt pulses. It sits directly downstream of the note sequencer and replaces the bare PWM instance there.

## Interface
- `W`, default 32: width of the period, duty and counter values.
- `clk`  in  1  system clock (50 MHz).
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  level; 1 = play, 0 = silence at the next boundary.
- `load`  in  1  single-cycle strobe; captures `period_in`/`duty_in`.
- `period_in`  in  W  PWM period in clk cycles.
- `duty_in`  in  W  high time in clk cycles.
- `pwm_out`  out  1  tone output to the buzzer.
- `period_done`  out  1  one-cycle pulse when a full period completes.
- `pending`  out  1  a captured value is waiting for a boundary.
- `active`  out  1  1 while the FSM is in RUN.

## Operation
- Registers:
  - `cnt` (W bits).
  - Active pair `act_p`, `act_d`.
  - Shadow pair `shd_p`, `shd_d`.
  - `pending` flag.
  - FSM state: IDLE or RUN.
- `load`=1 outside a boundary cycle: shadow <= inputs, `pending` <= 1. Repeated loads overwrite the shadow (last wins).
- Effective next pair at an update point, highest priority first:
  - `load` inputs, if `load`=1 in that cycle (bypass).
  - Otherwise the shadow, if `pending`=1.
  - Otherwise the active pair.
- When the effective pair is applied, `pending` clears.
- IDLE:
  - `cnt`=0 and `pwm_out`=0.
  - Go to RUN when `en`=1 and effective period >= 2.
  - On that transition, apply the effective pair; `cnt`=0 in the first RUN cycle.
- RUN:
  - `cnt` counts 0..`act_p`-1.
  - `pwm_out` = (`cnt` < `act_d`), evaluated on the current registered `cnt`/`act_d`. It must be driven from a flop (lookahead on next-state values), never from a combinational compare.
- Boundary = RUN cycle with `cnt` == `act_p`-1. In that cycle:
  - `period_done` is 1.
  - Apply the effective pair; `cnt` <= 0.
  - If `en`=0, or the new period is < 2, go to IDLE. Otherwise stay in RUN.
- `en` falling mid-period: the current period completes unchanged and `pwm_out` is 0 from the next cycle.
- `en` rising while in RUN: no effect.
- Clamping:
  - `act_d`=0 gives `pwm_out` constantly 0 in RUN.
  - `act_d` >= `act_p` gives constantly 1 in RUN.
  - `period_done` still pulses in both cases.
- Period 0 or 1 is treated as "silent": the block remains in or returns to IDLE.
- Comparisons are unsigned, full W bits. No wrap arithmetic beyond `cnt` reset to 0 at the boundary.
- `active` = (state == RUN).

## Timing
- Reset values (asynchronous, immediate, including mid-period):
  - state IDLE.
  - `cnt`, `act_p`, `act_d`, `shd_p`, `shd_d` = 0.
  - `pending`, `pwm_out`, `period_done`, `active` = 0.
- Start latency: `en`=1 and `load` in cycle t (from IDLE) → `active`=1 and first `pwm_out` high (if `duty_in` > 0) in cycle t+1.
- Update latency: a load in a non-boundary cycle is applied at the next boundary. `pending` is 1 from the cycle after the load until the cycle after that boundary.
- Load coinciding with a boundary: new values govern the very next period, and `pending` stays 0.
- Stop latency: `pwm_out`/`active` drop in the cycle after the boundary at which `en` is sampled 0.
- `period_done` fires every `act_p` cycles while running, exactly one cycle wide, aligned with the last count.

## Test plan
- Basic tone: reset, then `load` period=4, duty=2 with `en`=1. Required:
  - `pwm_out` = 1,1,0,0 repeating from t+1.
  - `period_done` on every 4th cycle.
  - `pending` stays 0.
- Deferred update: running at 4/2, `load` 6/3 at `cnt`=1. Required:
  - `pending`=1.
  - Current period finishes as 1,1,0,0.
  - Then 1,1,1,0,0,0.
  - `pending` clears after the boundary.
- Graceful stop: running at 8/4, drop `en` at `cnt`=2. Required:
  - `pwm_out` = 1,0,0,0,0 for `cnt`=3..7.
  - `period_done` at `cnt`=7.
  - `active`=0 and `pwm_out`=0 afterwards.
- Clamps: duty=0 gives `pwm_out` constantly 0 with `period_done` every period. Duty=9 with period=5 gives constantly 1. Period=1 with `en`=1 keeps `active`=0.
- Boundary collision: `load` 3/1 exactly on the boundary cycle of a 4/2 run. Required: next period is 1,0,0 and `pending` never asserts.
- Async reset mid-run: assert `rst` between clock edges at `cnt`=2. Required: all outputs 0 immediately and the FSM in IDLE; no output until a new `load` with `en`=1.
